bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter for the system bus; owns exclusive grant of the shared bus between master 1 and master 2.
- Supports split transactions: a slave may park the current owner and hand the bus to the other master until the slave signals release.
- Sits between the two master ports and the bus mux/slave decoder in top; grant outputs drive the address/data/control mux selects.

Parameters:
- ARB_W, 2, width of the arb_state debug output (fixed encoding, not for resizing).
- HOLD_W, 8, width of the hold-cycle counter.

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous active-low reset
- m1_req  in  1  master 1 requests the bus; held high for the whole transaction
- m2_req  in  1  master 2 requests the bus; held high for the whole transaction
- slave_split  in  1  one-cycle pulse: the addressed slave splits the current owner
- split_release  in  1  one-cycle pulse: the split slave is ready and the parked master may resume
- m1_grant  out  1  bus granted to master 1
- m2_grant  out  1  bus granted to master 2
- m1_split  out  1  master 1 is parked (split outstanding)
- m2_split  out  1  master 2 is parked (split outstanding)
- bus_busy  out  1  either grant is high
- hold_cnt  out  HOLD_W  cycles the current owner has held the bus; saturates
- arb_state  out  ARB_W  00 IDLE, 01 GNT1, 10 GNT2

Behaviour:
- Reset (rst low, async): state IDLE; all grants, split flags and bus_busy are 0; hold_cnt is 0.
- Grants are registered and decoded from a one-hot state, so m1_grant and m2_grant are never high together.
- Eligibility: m1 is eligible when m1_req=1 and m1_split=0; m2 likewise.
- IDLE: if any master is eligible, go to the selected GNTx on the next edge (1-cycle request-to-grant latency). Otherwise stay in IDLE.
- Selection (default): fixed priority, m1 over m2.
- GNTx, owner keeps its request: stay in GNTx. hold_cnt increments each cycle and saturates at all-ones.
- GNTx, owner drops its request: if the other master is eligible, go directly to GNTother on the same edge. No idle cycle is inserted and hold_cnt is reset to 0. Otherwise go to IDLE.
- Split: slave_split=1 in GNTx while no split is outstanding sets mx_split=1 and releases the owner. The next state is GNTother if the other master is eligible, else IDLE.
- slave_split and a request drop in the same cycle: split takes precedence and the flag is still set.
- Only one split may be outstanding. A slave_split while the other master's split flag is already set is ignored; the owner keeps the grant.
- slave_split in IDLE is ignored.
- split_release clears whichever split flag is set; with no flag set it is a no-op.
- split_release and slave_split in the same cycle: the release is applied first, then the split.
- A released master is eligible from the cycle after the flag clears. It does not preempt the current owner; it waits for that owner to drop its request.
- The parked master may keep its request high while parked; it receives no grant until released.
- bus_busy = m1_grant | m2_grant, registered with the grants.
- hold_cnt is 0 in IDLE and reloads to 0 on every grant change.

Optional Feature:
- Macro: ARB_RR_EN.
- With ARB_RR_EN defined: round-robin selection. A last_owner register is updated on each grant. When both masters are eligible at a decision point, the master that was not last_owner wins. last_owner resets to m2, so m1 wins the first contention.
- Without ARB_RR_EN: fixed priority, m1 always wins contention. The last_owner register is not built.

Decomposition:
- Package bus_arb_pkg holds:
  - the state encoding constants IDLE/GNT1/GNT2;
  - the ARB_W and HOLD_W defaults;
  - the owner id constants M1=0 and M2=1.
- One sub-module, bus_arb_pick: combinational selector with inputs elig1, elig2 and last_owner, output winner.
  - It contains the ARB_RR_EN switch, so the FSM in bus_arbiter stays identical in both builds.

Test Plan:
- Reset and single request: hold rst low for 3 cycles, then raise m1_req for 10 cycles and drop it -> m1_grant rises 1 cycle after the request; hold_cnt reaches 9; grant falls 1 cycle after the request drops; arb_state returns to 00.
- Contention: raise m1_req and m2_req together -> m1_grant is granted. Drop m1_req after 5 cycles -> m2_grant rises on the same edge that m1_grant falls, with no IDLE cycle and no overlap.
- Split: m1 granted, m2_req high, pulse slave_split -> m1_split=1 and m2_grant=1 next cycle. m2 drops its request -> IDLE, even though m1_req is still high. Pulse split_release -> m1_grant 2 cycles later.
- Second split ignored: m1 parked and m2 owning, pulse slave_split -> m2_grant stays 1 and m2_split stays 0.
- Async reset mid-transfer: drop rst while m2_grant=1, between clock edges -> all outputs are 0 immediately. After rst rises with m2_req still high -> m2_grant returns 1 cycle later.
- ARB_RR_EN build: m1 and m2 request continuously, each owner dropping its request for 1 cycle after 4 cycles -> grants alternate m1, m2, m1, m2. In the default build the same stimulus gives m1 on every decision where m2 is not the only eligible master.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the two-master bus arbiter.
package bus_arb_pkg;

  localparam int unsigned ARB_W_DEF  = 2;
  localparam int unsigned HOLD_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT1 = 2'b01,
    GNT2 = 2'b10
  } arb_state_t;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } owner_t;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational winner selection between two eligible masters.
// Build option: ARB_RR_EN selects round-robin; default is fixed priority m1 > m2.
module bus_arb_pick
  import bus_arb_pkg::*;
(
  input  logic   elig1,
  input  logic   elig2,
  input  owner_t last_owner,
  output owner_t winner
);

  // With no eligible master the result is unused; holding last_owner keeps the input live in both builds.
  always_comb begin
    winner = last_owner;
    if (elig1 && elig2) begin
`ifdef ARB_RR_EN
      winner = (last_owner == M1) ? M2 : M1;
`else
      winner = M1;
`endif
    end else if (elig1) begin
      winner = M1;
    end else if (elig2) begin
      winner = M2;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter with split-transaction parking.
// Build option: ARB_RR_EN enables round-robin contention resolution (last_owner register).
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned ARB_W  = ARB_W_DEF,
  parameter int unsigned HOLD_W = HOLD_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              m1_req,
  input  logic              m2_req,
  input  logic              slave_split,
  input  logic              split_release,
  output logic              m1_grant,
  output logic              m2_grant,
  output logic              m1_split,
  output logic              m2_split,
  output logic              bus_busy,
  output logic [HOLD_W-1:0] hold_cnt,
  output logic [ARB_W-1:0]  arb_state
);

  arb_state_t state;
  arb_state_t state_nxt;
  owner_t     last_owner;
  owner_t     winner;
  logic       elig1;
  logic       elig2;
  logic       held1;
  logic       held2;
  logic       split_acc;
  logic       m1_split_nxt;
  logic       m2_split_nxt;

  assign elig1 = m1_req & ~m1_split;
  assign elig2 = m2_req & ~m2_split;

  bus_arb_pick u_pick (
    .elig1      (elig1),
    .elig2      (elig2),
    .last_owner (last_owner),
    .winner     (winner)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Release is applied before a same-cycle split, so a split can land right after its predecessor clears.
  always_comb begin
    held1        = m1_split & ~split_release;
    held2        = m2_split & ~split_release;
    split_acc    = slave_split && (state != IDLE) && !held1 && !held2;
    m1_split_nxt = held1 | (split_acc && (state == GNT1));
    m2_split_nxt = held2 | (split_acc && (state == GNT2));
    state_nxt    = state;
    case (state)
      IDLE: begin
        if (elig1 || elig2) begin
          state_nxt = (winner == M1) ? GNT1 : GNT2;
        end
      end
      GNT1: begin
        if (split_acc || !m1_req) begin
          state_nxt = elig2 ? GNT2 : IDLE;
        end
      end
      GNT2: begin
        if (split_acc || !m2_req) begin
          state_nxt = elig1 ? GNT1 : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m1_grant  = (state == GNT1);
    m2_grant  = (state == GNT2);
    bus_busy  = (state == GNT1) || (state == GNT2);
    arb_state = ARB_W'(state);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      m1_split <= 1'b0;
      m2_split <= 1'b0;
    end else begin
      m1_split <= m1_split_nxt;
      m2_split <= m2_split_nxt;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
    end else if ((state_nxt != state) || (state_nxt == IDLE)) begin
      hold_cnt <= '0;
    end else if (hold_cnt != '1) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      last_owner <= M2;
    end else if (state_nxt == GNT1) begin
      last_owner <= M1;
    end else if (state_nxt == GNT2) begin
      last_owner <= M2;
    end
  end
`else
  assign last_owner = M2;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (default build, fixed priority).
module tb_bus_arbiter;

  logic       clock;
  logic       rst;
  logic       m1_req;
  logic       m2_req;
  logic       slave_split;
  logic       split_release;
  logic       m1_grant;
  logic       m2_grant;
  logic       m1_split;
  logic       m2_split;
  logic       bus_busy;
  logic [7:0] hold_cnt;
  logic [1:0] arb_state;

  int unsigned n_assert;
  int unsigned n_fail;

  bus_arbiter #(.ARB_W(2), .HOLD_W(8)) dut (
    .clock         (clock),
    .rst           (rst),
    .m1_req        (m1_req),
    .m2_req        (m2_req),
    .slave_split   (slave_split),
    .split_release (split_release),
    .m1_grant      (m1_grant),
    .m2_grant      (m2_grant),
    .m1_split      (m1_split),
    .m2_split      (m2_split),
    .bus_busy      (bus_busy),
    .hold_cnt      (hold_cnt),
    .arb_state     (arb_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant pair, split pair, busy, state and count in one call.
  task automatic chk_all(input string tag, input logic g1, input logic g2,
                         input logic s1, input logic s2, input logic [1:0] st,
                         input logic [7:0] hc);
    chk({tag, ".m1_grant"},  32'(m1_grant),  32'(g1));
    chk({tag, ".m2_grant"},  32'(m2_grant),  32'(g2));
    chk({tag, ".m1_split"},  32'(m1_split),  32'(s1));
    chk({tag, ".m2_split"},  32'(m2_split),  32'(s2));
    chk({tag, ".bus_busy"},  32'(bus_busy),  32'(g1 | g2));
    chk({tag, ".arb_state"}, 32'(arb_state), 32'(st));
    chk({tag, ".hold_cnt"},  32'(hold_cnt),  32'(hc));
  endtask

  initial begin
    n_assert      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    m1_req        = 1'b0;
    m2_req        = 1'b0;
    slave_split   = 1'b0;
    split_release = 1'b0;

    #2;
    chk_all("reset", 0, 0, 0, 0, 2'b00, 8'd0);
    repeat (3) step();
    rst = 1'b1;
    step();
    chk_all("post_reset_idle", 0, 0, 0, 0, 2'b00, 8'd0);

    // Single request held for 10 cycles.
    m1_req = 1'b1;
    step();
    chk_all("single_grant", 1, 0, 0, 0, 2'b01, 8'd0);
    repeat (9) step();
    chk_all("single_hold9", 1, 0, 0, 0, 2'b01, 8'd9);
    m1_req = 1'b0;
    step();
    chk_all("single_drop", 0, 0, 0, 0, 2'b00, 8'd0);

    // Contention from IDLE, then direct hand-over.
    m1_req = 1'b1;
    m2_req = 1'b1;
    step();
    chk_all("contend_m1_wins", 1, 0, 0, 0, 2'b01, 8'd0);
    repeat (4) step();
    chk_all("contend_m1_hold", 1, 0, 0, 0, 2'b01, 8'd4);
    m1_req = 1'b0;
    step();
    chk_all("handover_m2", 0, 1, 0, 0, 2'b10, 8'd0);

    // m2 drops, m1 takes over directly.
    m1_req = 1'b1;
    m2_req = 1'b0;
    step();
    chk_all("handover_m1", 1, 0, 0, 0, 2'b01, 8'd0);
    m2_req = 1'b1;
    step();
    chk_all("m1_keeps", 1, 0, 0, 0, 2'b01, 8'd1);

    // Split parks m1, m2 takes the bus.
    slave_split = 1'b1;
    step();
    slave_split = 1'b0;
    chk_all("split_m1", 0, 1, 1, 0, 2'b10, 8'd0);

    // Second split while m1 is parked is ignored.
    slave_split = 1'b1;
    step();
    slave_split = 1'b0;
    chk_all("split_ignored", 0, 1, 1, 0, 2'b10, 8'd1);

    // m2 drops while m1 parked: IDLE despite m1_req.
    m2_req = 1'b0;
    step();
    chk_all("parked_idle", 0, 0, 1, 0, 2'b00, 8'd0);
    split_release = 1'b1;
    step();
    split_release = 1'b0;
    chk_all("release_clear", 0, 0, 0, 0, 2'b00, 8'd0);
    step();
    chk_all("release_grant", 1, 0, 0, 0, 2'b01, 8'd0);

    // Split in IDLE is ignored.
    m1_req = 1'b0;
    step();
    slave_split = 1'b1;
    step();
    slave_split = 1'b0;
    chk_all("split_in_idle", 0, 0, 0, 0, 2'b00, 8'd0);

    // Long ownership saturates hold_cnt.
    m2_req = 1'b1;
    step();
    chk_all("m2_grant", 0, 1, 0, 0, 2'b10, 8'd0);
    repeat (300) step();
    chk_all("hold_saturate", 0, 1, 0, 0, 2'b10, 8'hff);

    // Async reset between edges clears everything at once.
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 2'b00, 8'd0);
    step();
    chk_all("reset_held", 0, 0, 0, 0, 2'b00, 8'd0);
    rst = 1'b1;
    step();
    chk_all("reset_regrant", 0, 1, 0, 0, 2'b10, 8'd0);

    // Split and request drop in the same cycle: split wins, m1 takes over.
    m1_req      = 1'b1;
    m2_req      = 1'b0;
    slave_split = 1'b1;
    step();
    slave_split = 1'b0;
    chk_all("split_and_drop", 1, 0, 0, 1, 2'b01, 8'd0);

    // Release and split together: m2 cleared, m1 parked, m2 not yet eligible.
    m2_req        = 1'b1;
    split_release = 1'b1;
    slave_split   = 1'b1;
    step();
    split_release = 1'b0;
    slave_split   = 1'b0;
    chk_all("release_then_split", 0, 0, 1, 0, 2'b00, 8'd0);
    step();
    chk_all("released_m2_grant", 0, 1, 1, 0, 2'b10, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
